uart_vector_loader: RTL and testbench
=====================================

Name: uart_vector_loader

Overview:
Parametrised successor to the two-vector UART loader in the accelerator top level. It decodes a byte-stream command protocol from uart_rx and fills NCH vector memories with NELEM elements of EW bits each, assembling multi-byte elements little-endian. It also enforces an inter-byte timeout, raises per-channel ready flags, and forwards processing commands to the compute stage as one-cycle pulses. It sits between uart_rx and the BRAM write ports.

Parameters:
NCH, 2, number of vector channels (1..16)
NELEM, 1024, elements per vector (>=2)
EW, 8, element width in bits; must be a multiple of 8 (BPE = EW/8 bytes per element)
TIMEOUT_CYC, 100000, max clock cycles between bytes during a load; 0 disables the timeout
AW, $clog2(NELEM), write address width (derived)
CW, max(1,$clog2(NCH)), channel index width (derived)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_byte valid (uart_rx Rx_DV)
rx_byte  in  8  received byte
wr_en  out  1  memory write strobe, one cycle
wr_ch  out  CW  target channel for wr_en
wr_addr  out  AW  element address
wr_data  out  EW  assembled element
vect_ready  out  NCH  bit k = channel k holds a complete vector
busy  out  1  high while in LOAD
cmd_valid  out  1  one-cycle processing-command pulse
cmd_code  out  4  processing command code, held until next cmd_valid
err_cmd  out  1  one-cycle pulse: illegal opcode or channel
err_timeout  out  1  one-cycle pulse: load aborted on timeout
state_dbg  out  2  current state encoding, for LEDs

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, vect_ready = 0. Reset mid-load discards the partial vector.
- Opcode byte (IDLE only): high nibble = op, low nibble = arg.
  - 0x0: LOAD channel arg. If arg >= NCH, pulse err_cmd and stay in IDLE. Otherwise clear vect_ready[arg], latch the channel, zero elem/byte counters, go to LOAD.
  - 0x1: clear vect_ready[arg]; pulse err_cmd if arg >= NCH.
  - 0x2: cmd_valid=1 and cmd_code=arg on the next cycle.
  - Any other op: pulse err_cmd.
- All outputs are registered. Every response appears the cycle after the rx_valid that caused it.
- States: IDLE=0, LOAD=1.
  - IDLE -> LOAD on a legal 0x0 opcode.
  - LOAD -> IDLE when the last element is written, or on timeout.
- LOAD assembly:
  - byte i (0..BPE-1) of an element goes to bits [8i+7:8i].
  - On byte BPE-1, the next cycle has wr_en=1, wr_addr=elem_cnt, wr_data=assembled word, wr_ch=latched channel. Then elem_cnt increments and byte_cnt returns to 0.
- Last element (elem_cnt==NELEM-1): in the same cycle as its wr_en, vect_ready[ch] is set, busy drops and state returns to IDLE. elem_cnt does not wrap inside a load.
- Bytes in LOAD are always data, never opcodes.
- Timeout (TIMEOUT_CYC>0):
  - idle counter resets on entering LOAD and on every rx_valid.
  - Reaching TIMEOUT_CYC with no rx_valid: pulse err_timeout, return to IDLE, no write, vect_ready[ch] stays 0.
  - If the timeout expiry and rx_valid coincide, rx_valid wins and the counter resets.
- wr_en is never asserted outside LOAD. Only one of wr_en, cmd_valid, err_cmd or err_timeout is asserted in any cycle.
- Other channels' vect_ready bits are untouched by a load.

Test Plan:
1. Load ch0. NCH=2, NELEM=4, EW=8; bytes 0x00,0x11,0x22,0x33,0x44 -> four wr_en pulses, wr_ch=0, addr 0..3, data 0x11..0x44. vect_ready=2'b01 in the cycle of the last write; busy low afterwards.
2. Multi-byte elements. EW=16, NELEM=2; bytes 0x01,0xCD,0xAB,0x34,0x12 -> wr_ch=1, (addr0,0xABCD), (addr1,0x1234). wr_en only after every second data byte; vect_ready=2'b10.
3. Illegal input. NCH=2; byte 0x05 -> err_cmd pulse, stays IDLE. Byte 0x70 -> err_cmd. Byte 0x23 -> cmd_valid pulse, cmd_code=3.
4. Timeout. TIMEOUT_CYC=50; 0x00, two data bytes, then silence -> err_timeout exactly 50 cycles after the last byte, 2 writes only, vect_ready[0]=0. Next byte 0x23 is decoded as an opcode (cmd_valid).
5. Reload and clear. Complete ch0 load, then 0x10 -> vect_ready[0] clears. Then 0x00 plus data, with reset asserted mid-load -> all outputs 0 the next cycle. After release, 0x21 gives cmd_valid.
6. Back-to-back strobes. rx_valid on consecutive cycles through a full NELEM=4 load -> wr_en on 4 consecutive cycles, no lost bytes, no wrap of wr_addr.

Source files
------------

// File: rtl/uart_vector_loader.sv
// Decodes the UART byte-stream command protocol and fills NCH vector memories (little-endian element assembly).
// Every response is registered one cycle after its rx_valid; there is no backpressure, so each strobe is consumed immediately.
module uart_vector_loader #(
   parameter int NCH         = 2,
   parameter int NELEM       = 1024,
   parameter int EW          = 8,
   parameter int TIMEOUT_CYC = 100000,
   parameter int AW          = $clog2(NELEM),
   parameter int CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           rx_valid,
   input  logic [7:0]     rx_byte,
   output logic           wr_en,
   output logic [CW-1:0]  wr_ch,
   output logic [AW-1:0]  wr_addr,
   output logic [EW-1:0]  wr_data,
   output logic [NCH-1:0] vect_ready,
   output logic           busy,
   output logic           cmd_valid,
   output logic [3:0]     cmd_code,
   output logic           err_cmd,
   output logic           err_timeout,
   output logic [1:0]     state_dbg
);

   localparam int BPE = EW / 8;
   localparam int BCW = (BPE > 1) ? $clog2(BPE) : 1;
   localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ch_q, ch_d;
   logic [AW-1:0]   elem_cnt_q, elem_d;
   logic [BCW-1:0]  byte_cnt_q, byte_d;
   logic [EW-1:0]   word_q, word_d, asm_word;
   logic [TW-1:0]   idle_cnt_q, idle_d;

   logic            wr_en_d, cmd_valid_d, err_cmd_d, err_timeout_d;
   logic [CW-1:0]   wr_ch_d;
   logic [AW-1:0]   wr_addr_d;
   logic [EW-1:0]   wr_data_d;
   logic [NCH-1:0]  vect_ready_d;
   logic [3:0]      cmd_code_d;

   logic [3:0]      op, arg;
   logic            arg_ok, last_byte, last_elem, timeout_hit;

   assign op          = rx_byte[7:4];
   assign arg         = rx_byte[3:0];
   assign arg_ok      = (32'(arg) < 32'(NCH));
   assign last_byte   = (byte_cnt_q == BCW'(BPE - 1));
   assign last_elem   = (elem_cnt_q == AW'(NELEM - 1));
   // A strobe in the expiry cycle takes priority, so rx_valid masks the timeout.
   assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q == LOAD) && !rx_valid &&
                        (idle_cnt_q == TO_LAST);

   assign busy      = (state_q == LOAD);
   assign state_dbg = {1'b0, state_q};

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (rx_valid && op == 4'h0 && arg_ok) state_d = LOAD;
         LOAD: begin
            if (rx_valid && last_byte && last_elem) state_d = IDLE;
            else if (timeout_hit)                   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_en_d       = 1'b0;
      wr_ch_d       = wr_ch;
      wr_addr_d     = wr_addr;
      wr_data_d     = wr_data;
      vect_ready_d  = vect_ready;
      cmd_valid_d   = 1'b0;
      cmd_code_d    = cmd_code;
      err_cmd_d     = 1'b0;
      err_timeout_d = 1'b0;
      ch_d          = ch_q;
      elem_d        = elem_cnt_q;
      byte_d        = byte_cnt_q;
      word_d        = word_q;
      idle_d        = idle_cnt_q;
      asm_word      = word_q;
      asm_word[8*byte_cnt_q +: 8] = rx_byte;

      case (state_q)
         IDLE: begin
            idle_d = '0;
            if (rx_valid) begin
               case (op)
                  4'h0: begin
                     if (arg_ok) begin
                        vect_ready_d[arg[CW-1:0]] = 1'b0;
                        ch_d   = arg[CW-1:0];
                        elem_d = '0;
                        byte_d = '0;
                        word_d = '0;
                     end else begin
                        err_cmd_d = 1'b1;
                     end
                  end
                  4'h1: begin
                     if (arg_ok) vect_ready_d[arg[CW-1:0]] = 1'b0;
                     else        err_cmd_d = 1'b1;
                  end
                  4'h2: begin
                     cmd_valid_d = 1'b1;
                     cmd_code_d  = arg;
                  end
                  default: err_cmd_d = 1'b1;
               endcase
            end
         end
         LOAD: begin
            if (rx_valid) begin
               idle_d = '0;
               if (last_byte) begin
                  wr_en_d   = 1'b1;
                  wr_ch_d   = ch_q;
                  wr_addr_d = elem_cnt_q;
                  wr_data_d = asm_word;
                  byte_d    = '0;
                  word_d    = '0;
                  if (last_elem) begin
                     vect_ready_d[ch_q] = 1'b1;
                     elem_d = '0;
                  end else begin
                     elem_d = elem_cnt_q + 1'b1;
                  end
               end else begin
                  word_d = asm_word;
                  byte_d = byte_cnt_q + 1'b1;
               end
            end else if (timeout_hit) begin
               err_timeout_d = 1'b1;
               elem_d = '0;
               byte_d = '0;
               word_d = '0;
               idle_d = '0;
            end else if (TIMEOUT_CYC > 0) begin
               idle_d = idle_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en       <= 1'b0;
         wr_ch       <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         vect_ready  <= '0;
         cmd_valid   <= 1'b0;
         cmd_code    <= '0;
         err_cmd     <= 1'b0;
         err_timeout <= 1'b0;
         ch_q        <= '0;
         elem_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         word_q      <= '0;
         idle_cnt_q  <= '0;
      end else begin
         wr_en       <= wr_en_d;
         wr_ch       <= wr_ch_d;
         wr_addr     <= wr_addr_d;
         wr_data     <= wr_data_d;
         vect_ready  <= vect_ready_d;
         cmd_valid   <= cmd_valid_d;
         cmd_code    <= cmd_code_d;
         err_cmd     <= err_cmd_d;
         err_timeout <= err_timeout_d;
         ch_q        <= ch_d;
         elem_cnt_q  <= elem_d;
         byte_cnt_q  <= byte_d;
         word_q      <= word_d;
         idle_cnt_q  <= idle_d;
      end
   end

endmodule

// File: tb/tb_uart_vector_loader.sv
// Bench for uart_vector_loader: 8-bit and 16-bit element instances, write scoreboards popped on wr_en.
module tb_uart_vector_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   int          errors = 0;
   int          checks = 0;

   // 8-bit element instance: NCH=2, NELEM=4, TIMEOUT_CYC=50
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        wr_en, busy, cmd_valid, err_cmd, err_timeout;
   logic [0:0]  wr_ch;
   logic [1:0]  wr_addr, vect_ready, state_dbg;
   logic [7:0]  wr_data;
   logic [3:0]  cmd_code;

   // 16-bit element instance: NCH=2, NELEM=2
   logic        rx_valid16 = 1'b0;
   logic [7:0]  rx_byte16 = 8'h00;
   logic        wr_en16, busy16, cmd_valid16, err_cmd16, err_timeout16;
   logic [0:0]  wr_ch16, wr_addr16;
   logic [1:0]  vect_ready16, state_dbg16;
   logic [15:0] wr_data16;
   logic [3:0]  cmd_code16;

   typedef struct packed {logic [0:0] ch; logic [1:0] addr; logic [7:0] data;} exp8_t;
   typedef struct packed {logic [0:0] ch; logic [0:0] addr; logic [15:0] data;} exp16_t;
   exp8_t  q8[$];
   exp16_t q16[$];

   uart_vector_loader #(.NCH(2), .NELEM(4), .EW(8), .TIMEOUT_CYC(50)) dut (
      .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
      .vect_ready(vect_ready), .busy(busy), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .err_cmd(err_cmd), .err_timeout(err_timeout), .state_dbg(state_dbg));

   uart_vector_loader #(.NCH(2), .NELEM(2), .EW(16), .TIMEOUT_CYC(50)) dut16 (
      .clock(clock), .reset(reset), .rx_valid(rx_valid16), .rx_byte(rx_byte16),
      .wr_en(wr_en16), .wr_ch(wr_ch16), .wr_addr(wr_addr16), .wr_data(wr_data16),
      .vect_ready(vect_ready16), .busy(busy16), .cmd_valid(cmd_valid16), .cmd_code(cmd_code16),
      .err_cmd(err_cmd16), .err_timeout(err_timeout16), .state_dbg(state_dbg16));

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Write scoreboards and one-pulse-per-cycle check, sampled on the falling edge.
   always @(negedge clock) begin
      exp8_t  e8;
      exp16_t e16;
      if (wr_en) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL wr8_unexpected: ch=%0d addr=%0d data=%h, none expected", wr_ch, wr_addr, wr_data);
         end else begin
            e8 = q8.pop_front();
            if ({wr_ch, wr_addr, wr_data} !== e8) begin
               errors++;
               $display("FAIL wr8: got ch=%0d addr=%0d data=%h want ch=%0d addr=%0d data=%h",
                        wr_ch, wr_addr, wr_data, e8.ch, e8.addr, e8.data);
            end
         end
      end
      if (wr_en16) begin
         checks++;
         if (q16.size() == 0) begin
            errors++;
            $display("FAIL wr16_unexpected: ch=%0d addr=%0d data=%h, none expected", wr_ch16, wr_addr16, wr_data16);
         end else begin
            e16 = q16.pop_front();
            if ({wr_ch16, wr_addr16, wr_data16} !== e16) begin
               errors++;
               $display("FAIL wr16: got ch=%0d addr=%0d data=%h want ch=%0d addr=%0d data=%h",
                        wr_ch16, wr_addr16, wr_data16, e16.ch, e16.addr, e16.data);
            end
         end
      end
      if (wr_en | cmd_valid | err_cmd | err_timeout) begin
         checks++;
         if (32'(wr_en) + 32'(cmd_valid) + 32'(err_cmd) + 32'(err_timeout) > 1) begin
            errors++;
            $display("FAIL pulse_exclusive: wr_en=%b cmd_valid=%b err_cmd=%b err_timeout=%b, want at most one",
                     wr_en, cmd_valid, err_cmd, err_timeout);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic send16(input logic [7:0] b);
      @(negedge clock);
      rx_valid16 = 1'b1;
      rx_byte16  = b;
      @(negedge clock);
      rx_valid16 = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++;
      if ({wr_en, wr_ch, wr_addr, wr_data, vect_ready, busy, cmd_valid, cmd_code,
           err_cmd, err_timeout, state_dbg} !== 25'd0) begin
         errors++;
         $display("FAIL reset_outputs: wr_en=%b addr=%0d data=%h vr=%b busy=%b cmd=%b/%h err=%b/%b st=%0d, want all 0",
                  wr_en, wr_addr, wr_data, vect_ready, busy, cmd_valid, cmd_code, err_cmd, err_timeout, state_dbg);
      end
      checks++;
      if ({vect_ready16, busy16, state_dbg16} !== 5'd0) begin
         errors++;
         $display("FAIL reset_outputs16: vr=%b busy=%b st=%0d, want 0", vect_ready16, busy16, state_dbg16);
      end
      reset = 1'b0;
   endtask

   task automatic test_load_ch0();
      send(8'h00);
      checks++;
      if (busy !== 1'b1 || state_dbg !== 2'd1) begin
         errors++;
         $display("FAIL load_enter: busy=%b state=%0d, want 1/1", busy, state_dbg);
      end
      for (int i = 0; i < 4; i++) begin
         q8.push_back('{ch: 1'b0, addr: 2'(i), data: 8'h11 * 8'(i + 1)});
         send(8'h11 * 8'(i + 1));
         if (i < 3) begin
            checks++;
            if (vect_ready !== 2'b00 || busy !== 1'b1) begin
               errors++;
               $display("FAIL load_mid: elem %0d vr=%b busy=%b, want 00/1", i, vect_ready, busy);
            end
         end
      end
      checks++;
      if (wr_en !== 1'b1 || vect_ready !== 2'b01 || busy !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL load_last: wr_en=%b vr=%b busy=%b st=%0d, want 1/01/0/0", wr_en, vect_ready, busy, state_dbg);
      end
   endtask

   task automatic test_multibyte();
      q16.push_back('{ch: 1'b1, addr: 1'b0, data: 16'hABCD});
      q16.push_back('{ch: 1'b1, addr: 1'b1, data: 16'h1234});
      send16(8'h01);
      send16(8'hCD);
      checks++;
      if (wr_en16 !== 1'b0) begin
         errors++;
         $display("FAIL mb_half: wr_en=%b after low byte, want 0", wr_en16);
      end
      send16(8'hAB);
      checks++;
      if (wr_en16 !== 1'b1) begin
         errors++;
         $display("FAIL mb_full: wr_en=%b after high byte, want 1", wr_en16);
      end
      send16(8'h34);
      send16(8'h12);
      checks++;
      if (wr_en16 !== 1'b1 || vect_ready16 !== 2'b10 || busy16 !== 1'b0) begin
         errors++;
         $display("FAIL mb_last: wr_en=%b vr=%b busy=%b, want 1/10/0", wr_en16, vect_ready16, busy16);
      end
   endtask

   task automatic test_illegal();
      send(8'h05);
      checks++;
      if (err_cmd !== 1'b1 || state_dbg !== 2'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_load_ch: err_cmd=%b st=%0d busy=%b, want 1/0/0", err_cmd, state_dbg, busy);
      end
      @(negedge clock);
      checks++;
      if (err_cmd !== 1'b0) begin
         errors++;
         $display("FAIL err_cmd_pulse: err_cmd=%b one cycle later, want 0", err_cmd);
      end
      send(8'h70);
      checks++;
      if (err_cmd !== 1'b1) begin
         errors++;
         $display("FAIL bad_op: err_cmd=%b, want 1", err_cmd);
      end
      send(8'h12);
      checks++;
      if (err_cmd !== 1'b1 || vect_ready !== 2'b01) begin
         errors++;
         $display("FAIL bad_clear_ch: err_cmd=%b vr=%b, want 1/01", err_cmd, vect_ready);
      end
      send(8'h23);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 4'd3 || err_cmd !== 1'b0) begin
         errors++;
         $display("FAIL cmd_pulse: cmd_valid=%b code=%0d err=%b, want 1/3/0", cmd_valid, cmd_code, err_cmd);
      end
      @(negedge clock);
      checks++;
      if (cmd_valid !== 1'b0 || cmd_code !== 4'd3) begin
         errors++;
         $display("FAIL cmd_hold: cmd_valid=%b code=%0d, want 0/3", cmd_valid, cmd_code);
      end
   endtask

   task automatic test_timeout();
      int seen;
      q8.push_back('{ch: 1'b0, addr: 2'd0, data: 8'h5A});
      q8.push_back('{ch: 1'b0, addr: 2'd1, data: 8'hA5});
      send(8'h00);
      send(8'h5A);
      send(8'hA5);
      seen = 0;
      for (int k = 1; k <= 60 && seen == 0; k++) begin
         @(negedge clock);
         if (err_timeout === 1'b1) seen = k;
      end
      checks++;
      if (seen != 50) begin
         errors++;
         $display("FAIL timeout_cycles: err_timeout after %0d cycles (0 = never), want 50", seen);
      end
      checks++;
      if (vect_ready !== 2'b00 || busy !== 1'b0 || state_dbg !== 2'd0) begin
         errors++;
         $display("FAIL timeout_state: vr=%b busy=%b st=%0d, want 00/0/0", vect_ready, busy, state_dbg);
      end
      @(negedge clock);
      checks++;
      if (err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: err_timeout=%b next cycle, want 0", err_timeout);
      end
      send(8'h23);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 4'd3 || wr_en !== 1'b0) begin
         errors++;
         $display("FAIL timeout_opcode: cmd_valid=%b code=%0d wr_en=%b, want 1/3/0", cmd_valid, cmd_code, wr_en);
      end
   endtask

   task automatic test_reload_clear();
      send(8'h00);
      for (int i = 0; i < 4; i++) begin
         q8.push_back('{ch: 1'b0, addr: 2'(i), data: 8'hC0 + 8'(i)});
         send(8'hC0 + 8'(i));
      end
      checks++;
      if (vect_ready !== 2'b01) begin
         errors++;
         $display("FAIL reload_done: vr=%b, want 01", vect_ready);
      end
      send(8'h10);
      checks++;
      if (vect_ready !== 2'b00 || err_cmd !== 1'b0) begin
         errors++;
         $display("FAIL clear_ch0: vr=%b err=%b, want 00/0", vect_ready, err_cmd);
      end
      send(8'h00);
      q8.push_back('{ch: 1'b0, addr: 2'd0, data: 8'h77});
      send(8'h77);
      q8.push_back('{ch: 1'b0, addr: 2'd1, data: 8'h88});
      send(8'h88);
      @(negedge clock);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = 8'h99;
      @(negedge clock);
      rx_valid = 1'b0;
      checks++;
      if ({wr_en, wr_ch, wr_addr, wr_data, vect_ready, busy, cmd_valid, cmd_code,
           err_cmd, err_timeout, state_dbg} !== 25'd0) begin
         errors++;
         $display("FAIL midload_reset: wr_en=%b addr=%0d data=%h vr=%b busy=%b cmd=%b/%h st=%0d, want all 0",
                  wr_en, wr_addr, wr_data, vect_ready, busy, cmd_valid, cmd_code, state_dbg);
      end
      reset = 1'b0;
      send(8'h21);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_code !== 4'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_cmd: cmd_valid=%b code=%0d busy=%b, want 1/1/0", cmd_valid, cmd_code, busy);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) q8.push_back('{ch: 1'b1, addr: 2'(i), data: 8'hA0 + 8'(i)});
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = 8'h01;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (i > 0) begin
            checks++;
            if (wr_en !== 1'b1) begin
               errors++;
               $display("FAIL b2b_wr: beat %0d wr_en=%b, want 1", i - 1, wr_en);
            end
         end
         rx_byte = 8'hA0 + 8'(i);
      end
      @(negedge clock);
      rx_valid = 1'b0;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 2'd3 || vect_ready !== 2'b10 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_last: wr_en=%b addr=%0d vr=%b busy=%b, want 1/3/10/0", wr_en, wr_addr, vect_ready, busy);
      end
      @(negedge clock);
      checks++;
      if (wr_en !== 1'b0) begin
         errors++;
         $display("FAIL b2b_after: wr_en=%b, want 0", wr_en);
      end
   endtask

   initial begin
      test_reset();
      test_load_ch0();
      test_multibyte();
      test_illegal();
      test_timeout();
      test_reload_clear();
      test_back_to_back();
      repeat (2) @(negedge clock);
      checks++;
      if (q8.size() != 0 || q16.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d writes outstanding, want 0/0", q8.size(), q16.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
